// File: rtl/ls_7408_pkg.sv
// Shared definitions for the ls_7408 quad AND block: default sizes and counter helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a. The helpers take 32-bit operands, so GATES and CNT_W must be <= 32.
package ls_7408_pkg;

  localparam int GATES_DEF = 4;
  localparam int CNT_W_DEF = 16;

  // Number of set bits in v.
  function automatic logic [31:0] popcount(input logic [31:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

  // acc + inc, clamped to max_val instead of wrapping.
  function automatic logic [31:0] sat_add(input logic [31:0] acc,
                                          input logic [31:0] inc,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, acc} + {1'b0, inc};
    if (sum > {1'b0, max_val}) begin
      return max_val;
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/ls_7408_edge.sv
// Per-bit shadow register of the gate outputs with rise/fall pulse detection.
// Latency: q/rise/fall are one clk after d is sampled. Backpressure: none, runs every edge.
// Ports: clk, rst_n (async active-low), d (live gate outputs), q (registered d), rise/fall (1-cycle pulses).
module ls_7408_edge
  import ls_7408_pkg::*;
#(
  parameter int W = GATES_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      rise <= '0;
      fall <= '0;
    end else begin
      q    <= d;
      // Compare against the previous sample held in q.
      rise <= d & ~q;
      fall <= ~d & q;
    end
  end

endmodule

// File: rtl/ls_7408.sv
// Quad 2-input AND (74LS08) with a clocked shadow stage for debug: registered copy, edge pulses, activity count.
// Latency: y is combinational; y_q/y_rise/y_fall/act_cnt are one clk. Backpressure: none.
// Ports: a, b -> y (comb); clk, rst_n (async active-low), clr (sync clear of act_cnt) -> y_q, y_rise, y_fall, act_cnt.
// Option: define LS_7408_FAULT_INJ_EN to add fault_mask/fault_val stuck-at overrides on y.
module ls_7408
  import ls_7408_pkg::*;
#(
  parameter int GATES = GATES_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [GATES-1:0] a,
  input  logic [GATES-1:0] b,
`ifdef LS_7408_FAULT_INJ_EN
  input  logic [GATES-1:0] fault_mask,
  input  logic [GATES-1:0] fault_val,
`endif
  input  logic             clr,
  output logic [GATES-1:0] y,
  output logic [GATES-1:0] y_q,
  output logic [GATES-1:0] y_rise,
  output logic [GATES-1:0] y_fall,
  output logic [CNT_W-1:0] act_cnt
);

  localparam logic [31:0] CNT_MAX = (CNT_W >= 32) ? 32'hFFFF_FFFF
                                                  : ((32'd1 << CNT_W) - 32'd1);

  // Gate array; independent of clk and rst_n so glue logic sees it during reset.
`ifdef LS_7408_FAULT_INJ_EN
  // Masked bits are stuck at fault_val; the shadow stage observes the forced value.
  assign y = ((a & b) & ~fault_mask) | (fault_val & fault_mask);
`else
  assign y = a & b;
`endif

  ls_7408_edge #(
    .W(GATES)
  ) u_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (y),
    .q    (y_q),
    .rise (y_rise),
    .fall (y_fall)
  );

  // Transitions this edge = bits where live y differs from the last sample.
  logic [31:0] inc;
  logic [31:0] cnt_next;

  always_comb begin
    inc      = popcount(32'(y ^ y_q));
    cnt_next = sat_add(32'(act_cnt), inc, CNT_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_cnt <= '0;
    end else if (clr) begin
      act_cnt <= '0;
    end else begin
      act_cnt <= CNT_W'(cnt_next);
    end
  end

endmodule

// File: tb/tb_ls_7408.sv
// Self-checking bench for ls_7408 (GATES=4, CNT_W=6 so saturation is reachable quickly).
// Combinational vector table, hand sequences for reset/edge/saturation/clear, then randomized
// cycles with input glitches, clears and async resets checked against a bit-count model.
module tb_ls_7408;

  localparam int G    = 4;
  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;
  localparam int GM   = (1 << G) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr;
  logic [G-1:0]  a, b, y, y_q, y_rise, y_fall;
  logic [CW-1:0] act_cnt;
`ifdef LS_7408_FAULT_INJ_EN
  logic [G-1:0]  fault_mask, fault_val;
`endif

  int total = 0;
  int bad   = 0;
  bit run_clk = 1'b0;

  always #5 if (run_clk) clk = ~clk;

  ls_7408 #(
    .GATES(G),
    .CNT_W(CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
`ifdef LS_7408_FAULT_INJ_EN
    .fault_mask(fault_mask),
    .fault_val (fault_val),
`endif
    .clr       (clr),
    .y         (y),
    .y_q       (y_q),
    .y_rise    (y_rise),
    .y_fall    (y_fall),
    .act_cnt   (act_cnt)
  );

  // Reference model: last sampled output word and a clamped transition tally.
  int m_prev = 0;
  int m_cnt  = 0;
  int m_rise = 0;
  int m_fall = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = 0;
    m_cnt  = 0;
    m_rise = 0;
    m_fall = 0;
  endtask

  // One rising edge: update model from the inputs seen at the edge, then compare #1 later.
  task automatic step();
    int cur;
    int ch;
    @(posedge clk);
    cur    = int'(a) & int'(b);
    m_rise = cur & ~m_prev & GM;
    m_fall = ~cur & m_prev & GM;
    ch     = $countones(cur ^ m_prev);
    if (clr) m_cnt = 0;
    else     m_cnt = (m_cnt + ch > CMAX) ? CMAX : m_cnt + ch;
    m_prev = cur;
    #1;
    check("y_q",     32'(y_q),     32'(m_prev));
    check("y_rise",  32'(y_rise),  32'(m_rise));
    check("y_fall",  32'(y_fall),  32'(m_fall));
    check("act_cnt", 32'(act_cnt), 32'(m_cnt));
    check("y_live",  32'(y),       32'(int'(a) & int'(b)));
  endtask

  typedef struct {
    logic [G-1:0] a;
    logic [G-1:0] b;
    logic [G-1:0] y;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'b1010, 4'b1100, 4'b1000};
    vecs[1] = '{4'b1111, 4'b0101, 4'b0101};
    vecs[2] = '{4'b0000, 4'b1111, 4'b0000};
    vecs[3] = '{4'b0110, 4'b0011, 4'b0010};
    vecs[4] = '{4'b1001, 4'b1011, 4'b1001};
    vecs[5] = '{4'b1111, 4'b1111, 4'b1111};

    rst_n = 1'b0;
    clr   = 1'b0;
    a     = '0;
    b     = '0;
`ifdef LS_7408_FAULT_INJ_EN
    fault_mask = '0;
    fault_val  = '0;
`endif
    #10;
    check("rst_y_q",    32'(y_q),     32'd0);
    check("rst_rise",   32'(y_rise),  32'd0);
    check("rst_fall",   32'(y_fall),  32'd0);
    check("rst_cnt",    32'(act_cnt), 32'd0);

    // Combinational path with no clock running, held in reset.
    foreach (vecs[i]) begin
      a = vecs[i].a;
      b = vecs[i].b;
      #10;
      check($sformatf("comb_y[%0d]", i), 32'(y), 32'(vecs[i].y));
      check($sformatf("comb_yq[%0d]", i), 32'(y_q), 32'd0);
    end

`ifdef LS_7408_FAULT_INJ_EN
    fault_mask = 4'b0001;
    fault_val  = 4'b0000;
    #10;
    check("fault_forced", 32'(y), 32'h0000_000E);
    fault_mask = 4'b0000;
    #10;
    check("fault_cleared", 32'(y), 32'h0000_000F);
`endif

    // a=b=1111 still applied; release reset and start the clock.
    check("rst_cnt_hold", 32'(act_cnt), 32'd0);
    rst_n   = 1'b1;
    model_reset();
    run_clk = 1'b1;
    step();
    check("first_rise", 32'(y_rise),  32'h0000_000F);
    check("first_cnt",  32'(act_cnt), 32'd4);
    step();
    check("second_rise", 32'(y_rise), 32'd0);

    b = 4'b0101;
    step();
    check("fall_pat", 32'(y_fall),  32'h0000_000A);
    check("fall_cnt", 32'(act_cnt), 32'd6);

    // Drive the counter into saturation by toggling all gates.
    b = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      a = (i % 2 == 0) ? 4'b0000 : 4'b1111;
      step();
    end
    a = 4'b1111;
    step();
    check("sat_hold", 32'(act_cnt), 32'(CMAX));
    a = 4'b0000;
    step();
    check("sat_stay", 32'(act_cnt), 32'(CMAX));

    // Clear wins over a simultaneous 4-bit toggle; shadow still updates.
    a   = 4'b1111;
    clr = 1'b1;
    step();
    check("clr_cnt",  32'(act_cnt), 32'd0);
    check("clr_rise", 32'(y_rise),  32'h0000_000F);
    clr = 1'b0;

    // Randomized cycles with mid-cycle glitches, sporadic clears and async resets.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 24) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_yq",   32'(y_q),     32'd0);
        check("arst_rise", 32'(y_rise),  32'd0);
        check("arst_cnt",  32'(act_cnt), 32'd0);
        rst_n = 1'b1;
      end
      a = G'($urandom);
      b = G'($urandom);
      #1;
      a   = G'($urandom);
      b   = G'($urandom);
      clr = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
